// File: rtl/sweep_ctrl_pkg.sv
// Shared types for the sweep counter controller: FSM states and sweep mode encodings.
package sweep_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        UP   = 2'b01,
        DOWN = 2'b10
    } state_e;

    typedef enum logic [MODE_W-1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

endpackage

// File: rtl/updown_counter_core.sv
// Bare WIDTH-bit up/down counter datapath: load has priority over stepping.
module updown_counter_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en)
            count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
    end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Sweep sequencer over updown_counter_core: up ramp, down ramp or triangle between latched limits.
// Optional SWEEP_PAUSE_EN adds a pause input that freezes a running sweep.
module sweep_counter_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   lo_limit,
    input  logic [WIDTH-1:0]   hi_limit,
    input  logic [SWEEP_W-1:0] sweeps,
`ifdef SWEEP_PAUSE_EN
    input  logic               pause,
`endif
    output logic [WIDTH-1:0]   count,
    output logic               upcnt,
    output logic               busy,
    output logic               done,
    output logic               err
);

    state_e             state, state_n;
    logic [1:0]         mode_r;
    logic [WIDTH-1:0]   lo_r, hi_r;
    logic [SWEEP_W-1:0] sweeps_r, sweep_cnt, sweep_n, sweep_inc;
    logic               upcnt_n, busy_n, done_n, err_n, cfg_load;
    logic               ld, step, step_up, last_sweep, pause_act;
    logic [WIDTH-1:0]   ld_val;

`ifdef SWEEP_PAUSE_EN
    assign pause_act = pause;
`else
    assign pause_act = 1'b0;
`endif

    // sweeps_r == 0 means continuous: the sweep counter then wraps and never terminates the run
    assign sweep_inc  = sweep_cnt + SWEEP_W'(1);
    assign last_sweep = (sweeps_r != '0) && (sweep_inc == sweeps_r);

    updown_counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .en       (step),
        .up       (step_up),
        .count    (count)
    );

    always_comb begin
        state_n  = state;
        upcnt_n  = upcnt;
        busy_n   = busy;
        done_n   = 1'b0;
        err_n    = 1'b0;
        sweep_n  = sweep_cnt;
        cfg_load = 1'b0;
        ld       = 1'b0;
        ld_val   = lo_r;
        step     = 1'b0;
        step_up  = 1'b1;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    if (mode == MODE_RSVD || lo_limit > hi_limit) begin
                        err_n = 1'b1;
                    end else begin
                        cfg_load = 1'b1;
                        sweep_n  = '0;
                        busy_n   = 1'b1;
                        ld       = 1'b1;
                        if (mode == MODE_DOWN) begin
                            state_n = DOWN;
                            ld_val  = hi_limit;
                            upcnt_n = 1'b0;
                        end else begin
                            state_n = UP;
                            ld_val  = lo_limit;
                            upcnt_n = 1'b1;
                        end
                    end
                end
            end
            UP: begin
                if (stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (!pause_act) begin
                    if (count < hi_r) begin
                        step    = 1'b1;
                        step_up = 1'b1;
                    end else if (mode_r == MODE_TRI) begin
                        // turning point: a degenerate lo==hi range keeps the count at hi
                        state_n = DOWN;
                        upcnt_n = 1'b0;
                        ld      = 1'b1;
                        ld_val  = (lo_r == hi_r) ? hi_r : hi_r - WIDTH'(1);
                    end else begin
                        sweep_n = sweep_inc;
                        if (last_sweep) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else begin
                            ld     = 1'b1;
                            ld_val = lo_r;
                        end
                    end
                end
            end
            DOWN: begin
                if (stop) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else if (!pause_act) begin
                    if (count > lo_r) begin
                        step    = 1'b1;
                        step_up = 1'b0;
                    end else begin
                        sweep_n = sweep_inc;
                        if (last_sweep) begin
                            state_n = IDLE;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                        end else if (mode_r == MODE_TRI) begin
                            state_n = UP;
                            upcnt_n = 1'b1;
                            ld      = 1'b1;
                            ld_val  = (lo_r == hi_r) ? lo_r : lo_r + WIDTH'(1);
                        end else begin
                            ld     = 1'b1;
                            ld_val = hi_r;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            upcnt     <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            sweep_cnt <= '0;
            mode_r    <= MODE_UP;
            lo_r      <= '0;
            hi_r      <= '0;
            sweeps_r  <= '0;
        end else begin
            state     <= state_n;
            upcnt     <= upcnt_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            sweep_cnt <= sweep_n;
            if (cfg_load) begin
                mode_r   <= mode;
                lo_r     <= lo_limit;
                hi_r     <= hi_limit;
                sweeps_r <= sweeps;
            end
        end
    end

endmodule
